// File: rtl/pic_pkg.sv
// Shared definitions for the 8259A-style cascade logic.
// Bus width, slave ID type, ICW3 ID field and SP encoding.
package pic_pkg;

  localparam int CAS_W = 3;

  typedef logic [CAS_W-1:0] cas_id_t;

  localparam int ICW3_ID_LSB = 0;
  localparam int ICW3_ID_MSB = 2;

  typedef enum logic {
    SLAVE  = 1'b0,
    MASTER = 1'b1
  } sp_mode_e;

endpackage

// File: rtl/cascade_controller.sv
// Cascade-bus controller: master drives the slave ID on CAS,
// slave flags when the bus carries its own ICW3 ID.
module cascade_controller
  import pic_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  inout  wire  [CAS_W-1:0] CAS,
  input  logic             SP,
  input  logic [7:0]       ICW3,
  input  logic             control_signal,
  input  cas_id_t          desired_slave,
  output logic             flag
);

  logic    drv_en_q;
  logic    drv_en_d;
  cas_id_t cas_q;
  cas_id_t cas_d;
  logic    flag_q;
  logic    flag_d;
  cas_id_t my_id;
  logic    bus_match;
  logic    unused_icw3;

  assign my_id       = ICW3[ICW3_ID_MSB:ICW3_ID_LSB];
  assign unused_icw3 = ^ICW3[7:3];

  // Undriven or unknown bus bits must never count as a match.
  assign bus_match = (CAS === my_id);

  // Next-state: master tracks desired_slave, slave compares the bus.
  always_comb begin
    drv_en_d = 1'b0;
    cas_d    = cas_q;
    flag_d   = 1'b0;
    if (SP == MASTER) begin
      if (control_signal) begin
        drv_en_d = 1'b1;
        cas_d    = desired_slave;
      end
    end else begin
      flag_d = control_signal & bus_match;
    end
  end

  // State registers with synchronous reset overriding everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      drv_en_q <= 1'b0;
      cas_q    <= '0;
      flag_q   <= 1'b0;
    end else begin
      drv_en_q <= drv_en_d;
      cas_q    <= cas_d;
      flag_q   <= flag_d;
    end
  end

  assign CAS  = drv_en_q ? cas_q : {CAS_W{1'bz}};
  assign flag = flag_q;

endmodule

// File: tb/tb_cascade_controller.sv
// One master and two slaves on a shared CAS net, checked
// against a cycle-level model of the cascade protocol.
module tb_cascade_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ctl;
  logic       sp_m;
  logic [2:0] ds;
  logic [2:0] ds_noise;
  logic [7:0] icw_m;
  logic [7:0] icw_s2;
  logic [7:0] icw_s3;
  wire  [2:0] cas_bus;
  logic       flag1;
  logic       flag2;
  logic       flag3;

  int n_cmp = 0;
  int n_err = 0;

  // Model state: bus value (-1 = nobody drives) and three flags.
  int exp_bus;
  bit exp_f1;
  bit exp_f2;
  bit exp_f3;

  always #5 clk = ~clk;

  cascade_controller u_m (
    .clk(clk), .rst_n(rst_n), .CAS(cas_bus), .SP(sp_m),
    .ICW3(icw_m), .control_signal(ctl),
    .desired_slave(ds), .flag(flag1)
  );

  cascade_controller u_s2 (
    .clk(clk), .rst_n(rst_n), .CAS(cas_bus), .SP(1'b0),
    .ICW3(icw_s2), .control_signal(ctl),
    .desired_slave(ds_noise), .flag(flag2)
  );

  cascade_controller u_s3 (
    .clk(clk), .rst_n(rst_n), .CAS(cas_bus), .SP(1'b0),
    .ICW3(icw_s3), .control_signal(ctl),
    .desired_slave(ds_noise), .flag(flag3)
  );

  task automatic check(string tag, logic [7:0] obs,
                       logic [7:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)",
               tag, obs, exp, $time);
    end
  endtask

  function automatic bit sel(bit is_slave, int bus,
                             logic [7:0] icw);
    return is_slave && ctl && bus >= 0 && bus == int'(icw[2:0]);
  endfunction

  // Apply one clock edge to the model, using inputs held now.
  task automatic model_edge();
    int nb;
    if (!rst_n) begin
      nb = -1;
      exp_f1 = 0;
      exp_f2 = 0;
      exp_f3 = 0;
    end else begin
      nb = (sp_m && ctl) ? int'(ds) : -1;
      exp_f1 = sel(!sp_m, exp_bus, icw_m);
      exp_f2 = sel(1'b1, exp_bus, icw_s2);
      exp_f3 = sel(1'b1, exp_bus, icw_s3);
    end
    exp_bus = nb;
  endtask

  task automatic compare_all();
    check("m_drive", {7'd0, u_m.drv_en_q}, {7'd0, exp_bus >= 0});
    if (exp_bus >= 0)
      check("cas", {5'd0, cas_bus}, 8'(exp_bus));
    check("s_drive", {7'd0, u_s2.drv_en_q | u_s3.drv_en_q}, 8'd0);
    check("flag1", {7'd0, flag1}, {7'd0, exp_f1});
    check("flag2", {7'd0, flag2}, {7'd0, exp_f2});
    check("flag3", {7'd0, flag3}, {7'd0, exp_f3});
  endtask

  task automatic tick(int n = 1);
    for (int i = 0; i < n; i++) begin
      model_edge();
      @(posedge clk);
      @(negedge clk);
      compare_all();
    end
  endtask

  initial begin
    exp_bus  = -1;
    exp_f1   = 0;
    exp_f2   = 0;
    exp_f3   = 0;
    rst_n    = 1'b0;
    ctl      = 1'b1;
    sp_m     = 1'b1;
    ds       = 3'b110;
    ds_noise = 3'b101;
    icw_m    = 8'hF5;
    icw_s2   = 8'h06;
    icw_s3   = 8'h07;

    // Reset held with control active.
    tick(2);
    check("rst_cas_off", {7'd0, u_m.drv_en_q}, 8'd0);
    rst_n = 1'b1;

    // Unmatched ID.
    ds = 3'b010;
    tick(10);

    // Select slave 110.
    ctl = 1'b0;
    tick(1);
    ds  = 3'b110;
    ctl = 1'b1;
    tick(1);
    check("sel6_cas", {5'd0, cas_bus}, 8'h06);
    tick(1);
    check("sel6_f2", {7'd0, flag2}, 8'd1);
    tick(2);

    // Deassert, then select slave 111.
    ctl = 1'b0;
    tick(2);
    check("deassert_f2", {7'd0, flag2}, 8'd0);
    ds  = 3'b111;
    ctl = 1'b1;
    tick(2);
    check("sel7_f3", {7'd0, flag3}, 8'd1);
    tick(2);

    // Live ID change while active.
    ds = 3'b110;
    tick(1);
    check("live_cas", {5'd0, cas_bus}, 8'h06);
    tick(1);
    check("live_f2", {7'd0, flag2}, 8'd1);
    ds = 3'b111;
    tick(3);

    // Mode change: master drops to slave and back.
    sp_m = 1'b0;
    tick(3);
    check("mode_off", {7'd0, u_m.drv_en_q}, 8'd0);
    sp_m = 1'b1;
    tick(2);
    check("mode_on", {7'd0, u_m.drv_en_q}, 8'd1);

    // Mid-operation reset.
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(1);

    // Randomized traffic with occasional mode flips and resets.
    for (int k = 0; k < 400; k++) begin
      ds       = 3'($urandom_range(0, 7));
      ds_noise = 3'($urandom);
      if ($urandom_range(0, 3) == 0) ctl = ~ctl;
      if ($urandom_range(0, 15) == 0) sp_m = ~sp_m;
      rst_n = ($urandom_range(0, 40) != 0);
      icw_s2 = {5'($urandom), 3'b110};
      icw_s3 = {5'($urandom), 3'b111};
      tick(1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
